fp_to_int_cvt_pipe: RTL and testbench
=====================================

Name: fp_to_int_cvt_pipe

Overview:
Parametrised, 2-stage pipelined float-to-integer converter for the FP execution unit. It implements RISC-V FCVT.W.S and FCVT.WU.S semantics, selected per operation. It supports all five rounding modes, saturation, and NV/NX exception flags. It sits behind the FP reservation station with a valid/ready handshake and carries the ROB tag through; a flush input kills in-flight work on mispredict.

Parameters:
EXP_W, 8, exponent width of the input float.
MAN_W, 23, stored fraction width of the input float.
INT_W, 32, result integer width; legal range 8..64.
TAG_W, 6, width of the ROB tag carried alongside each operation.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  operation offered
in_ready  out  1  converter accepts the operation this cycle
in_data  in  1+EXP_W+MAN_W  IEEE-754 operand
in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
in_unsigned  in  1  1 = WU (unsigned result), 0 = W (signed result)
in_tag  in  TAG_W  ROB tag
out_valid  out  1  result available
out_ready  in  1  consumer (CDB arbiter) takes the result
out_data  out  INT_W  integer result
out_fflags  out  5  {NV,DZ,OF,UF,NX}; only NV and NX are ever set
out_tag  out  TAG_W  tag of the result

Behaviour:
- Transfer occurs on a cycle with valid && ready on the respective side. Latency is exactly 2 cycles from input transfer to out_valid when no stall occurs. Throughput is 1 op/cycle.
- Stage 1 (S1):
  - unpack sign, exponent, fraction; add the hidden bit for normals (none for subnormals).
  - classify the operand as zero, subnormal, normal, inf or NaN.
  - align the magnitude to an (INT_W+1)-bit integer part plus guard and sticky bits.
  - E = exp - bias; E > INT_W forces the overflow class.
- Stage 2 (S2):
  - apply the rounding increment (RNE: G&(L|S); RTZ: 0; RDN: neg&(G|S); RUP: !neg&(G|S); RMM: G).
  - negate if the sign is set, then apply saturation and flags.
- Each stage has its own valid bit; the pipeline advances only when the downstream stage is empty or transferring.
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - With out_ready low, the pipeline holds 2 ops and in_ready drops. No drops, no duplicates, order preserved.
- Saturation and flags (checks are made after rounding):
  - Signed: result > 2^(INT_W-1)-1 or NaN or +inf -> 2^(INT_W-1)-1, NV=1.
  - Signed: result < -2^(INT_W-1) or -inf -> -2^(INT_W-1), NV=1.
  - Unsigned: NaN, +inf, or result >= 2^INT_W -> all ones, NV=1.
  - Unsigned: negative operand whose rounded magnitude is >= 1, or -inf -> 0, NV=1.
  - Unsigned: negative operand rounding to 0 -> 0, NX only.
  - NX=1 when G|S is set and NV=0. NV suppresses NX.
  - Zero (±0) -> 0, no flags.
  - Subnormal -> 0 or ±1 per the rounding mode, NX=1.
- in_rm 101..111 is treated as RTZ. Dynamic rm is resolved upstream.
- flush: both valid bits are cleared at the next edge and an input offered in the same cycle is dropped. Flush takes priority over every transfer.
- rst: both valid bits cleared; out_valid=0, out_data=0, out_fflags=0, out_tag=0. in_ready=1 in the cycle after reset. Reset asserted mid-operation discards all in-flight ops.
- out_data/out_fflags/out_tag are held stable while out_valid && !out_ready.

Test Plan:
- Signed conversions:
  - RTZ 0x40490FDB (3.14159) -> 0x00000003, NX=1.
  - 0x40200000 (2.5): RNE -> 2, RUP -> 3, RMM -> 3, RDN -> 2, all NX=1.
  - 0xC0200000 (-2.5) RDN -> 0xFFFFFFFD, NX=1.
- Saturation boundaries:
  - signed 0x4F000000 (2^31) -> 0x7FFFFFFF, NV.
  - signed 0xCF000000 (-2^31) -> 0x80000000, no flags.
  - unsigned 0x4F7FFFFF -> 0xFFFFFF00, no flags.
  - unsigned 0x4F800000 -> 0xFFFFFFFF, NV.
- Specials:
  - NaN 0x7FC00000 signed -> 0x7FFFFFFF, NV; unsigned -> 0xFFFFFFFF, NV.
  - 0xFF800000 (-inf) signed -> 0x80000000, NV.
  - 0x80000000 (-0) -> 0, no flags.
- Unsigned negatives:
  - 0xBF000000 (-0.5) RTZ -> 0, NX only.
  - same operand RDN -> 0, NV.
  - 0xBF800000 (-1.0) -> 0, NV.
- Backpressure: 4 back-to-back ops with out_ready low for 3 cycles -> in_ready drops after 2 accepted; all 4 results emerge in order with the correct tags and no duplicates.
- Flush and reset:
  - flush while 2 ops are in flight plus 1 offered -> out_valid=0 next cycle and none of the 3 ever emerges.
  - rst mid-stream -> all outputs 0, and a subsequent op completes in 2 cycles.

Source files
------------

// File: rtl/fp_to_int_cvt_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_int_cvt_pipe
// Purpose  : Two-stage pipelined IEEE-754 float to integer converter
//            (FCVT.W.S / FCVT.WU.S semantics). Supports all five rounding modes,
//            saturation, and NV/NX flags. Valid/ready on both sides, with the
//            ROB tag carried alongside each operation and a flush that kills
//            in-flight work.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            flush              - kill everything in flight (plus the offered op)
//            in_valid/in_ready  - input handshake
//            in_data            - float operand {sign, exponent, fraction}
//            in_rm              - rounding mode (RNE,RTZ,RDN,RUP,RMM; 101..111 = RTZ)
//            in_unsigned        - 1: unsigned result, 0: signed result
//            in_tag             - ROB tag
//            out_valid/out_ready- output handshake
//            out_data           - integer result
//            out_fflags         - {NV,DZ,OF,UF,NX}
//            out_tag            - tag of the result
// Revision : 1.0 - initial release
// ============================================================================
module fp_to_int_cvt_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32,
  parameter int TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic [2:0]             in_rm,
  input  logic                   in_unsigned,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       out_data,
  output logic [4:0]             out_fflags,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  // Fraction bits kept after alignment: enough to hold the whole significand
  // when the unbiased exponent is -1 (value in [0.5, 1)).
  localparam int FB   = MAN_W + 1;
  localparam int AW   = INT_W + 1 + FB;
  localparam int SHW  = $clog2(INT_W + 2);

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Magnitude limits, INT_W+2 bits wide to match the rounded magnitude.
  localparam logic [INT_W+1:0] SMAX_MAG = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [INT_W+1:0] SMIN_MAG = {3'b001, {(INT_W-1){1'b0}}};
  localparam logic [INT_W+1:0] ULIM_MAG = {2'b01,  {INT_W{1'b0}}};

  localparam logic [INT_W-1:0] RES_SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] RES_SMIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] RES_UMAX = {INT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Handshake / pipeline control
  // --------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_free, s1_free, in_fire, s1_adv;

  always_comb begin
    s2_free    = !s2_valid_q || out_ready;
    s1_free    = !s1_valid_q || s2_free;
    in_fire    = in_valid && s1_free && !flush;
    s1_adv     = s1_valid_q && s2_free;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_free) s1_valid_d = in_valid;
      if (s2_free) s2_valid_d = s1_valid_q;
    end
  end

  assign in_ready = s1_free;

  // --------------------------------------------------------------------------
  // Stage 1: unpack, classify, align
  // --------------------------------------------------------------------------
  logic                 in_sign;
  logic [EXP_W-1:0]     in_exp;
  logic [MAN_W-1:0]     in_frac;
  logic                 exp_max, exp_zero, frac_zero;
  logic                 is_nan_d, is_inf_d, is_zero_d, ovf_d;
  logic [MAN_W:0]       mant;
  logic signed [31:0]   unb_exp;
  logic [SHW-1:0]       sh;
  logic [AW-1:0]        aligned;
  logic [INT_W:0]       int_d;
  logic                 g_d, s_d;
  logic [2:0]           rm_d;

  assign in_sign = in_data[EXP_W+MAN_W];
  assign in_exp  = in_data[EXP_W+MAN_W-1:MAN_W];
  assign in_frac = in_data[MAN_W-1:0];

  always_comb begin
    exp_max   = &in_exp;
    exp_zero  = ~|in_exp;
    frac_zero = ~|in_frac;
    is_nan_d  = exp_max && !frac_zero;
    is_inf_d  = exp_max && frac_zero;
    is_zero_d = exp_zero && frac_zero;
    // Hidden bit only for normals; subnormals land in the "below one half"
    // path below because their biased exponent is zero.
    mant      = {!exp_zero, in_frac};
    unb_exp   = $signed(32'(in_exp)) - BIAS;
    sh        = '0;
    aligned   = '0;
    int_d     = '0;
    g_d       = 1'b0;
    s_d       = 1'b0;
    ovf_d     = 1'b0;
    if (!(is_nan_d || is_inf_d || is_zero_d)) begin
      if (unb_exp > INT_W) begin
        ovf_d = 1'b1;
      end else if (unb_exp < -1) begin
        // Nonzero magnitude strictly below one half: only sticky survives.
        s_d = 1'b1;
      end else begin
        sh      = SHW'(unb_exp + 1);
        aligned = AW'(mant) << sh;
        int_d   = aligned[AW-1:FB];
        g_d     = aligned[FB-1];
        s_d     = |aligned[FB-2:0];
      end
    end
    rm_d = (in_rm > RM_RMM) ? RM_RTZ : in_rm;
  end

  logic             s1_sign_q, s1_nan_q, s1_inf_q, s1_ovf_q;
  logic [INT_W:0]   s1_int_q;
  logic             s1_g_q, s1_s_q, s1_uns_q;
  logic [2:0]       s1_rm_q;
  logic [TAG_W-1:0] s1_tag_q;

  // --------------------------------------------------------------------------
  // Stage 2: round, negate, saturate, flags
  // --------------------------------------------------------------------------
  logic             inc;
  logic [INT_W+1:0] mag;
  logic [INT_W-1:0] res_d;
  logic             nv_d, nx_d;
  logic [4:0]       flags_d;

  always_comb begin
    case (s1_rm_q)
      RM_RNE:  inc = s1_g_q && (s1_int_q[0] || s1_s_q);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign_q && (s1_g_q || s1_s_q);
      RM_RUP:  inc = !s1_sign_q && (s1_g_q || s1_s_q);
      RM_RMM:  inc = s1_g_q;
      default: inc = 1'b0;
    endcase
    mag = {1'b0, s1_int_q} + {{(INT_W+1){1'b0}}, inc};

    res_d = '0;
    nv_d  = 1'b0;
    if (!s1_uns_q) begin
      if (s1_nan_q || (!s1_sign_q && (s1_inf_q || s1_ovf_q || mag > SMAX_MAG))) begin
        res_d = RES_SMAX;
        nv_d  = 1'b1;
      end else if (s1_sign_q && (s1_inf_q || s1_ovf_q || mag > SMIN_MAG)) begin
        res_d = RES_SMIN;
        nv_d  = 1'b1;
      end else if (s1_sign_q) begin
        // mag <= 2^(INT_W-1) here, so the truncated two's complement is exact.
        res_d = -mag[INT_W-1:0];
      end else begin
        res_d = mag[INT_W-1:0];
      end
    end else begin
      if (s1_nan_q || (!s1_sign_q && (s1_inf_q || s1_ovf_q || mag >= ULIM_MAG))) begin
        res_d = RES_UMAX;
        nv_d  = 1'b1;
      end else if (s1_sign_q && (s1_inf_q || s1_ovf_q || mag != '0)) begin
        res_d = '0;
        nv_d  = 1'b1;
      end else if (s1_sign_q) begin
        // Negative operand that rounded to zero: only inexact can be raised.
        res_d = '0;
      end else begin
        res_d = mag[INT_W-1:0];
      end
    end
    nx_d    = (s1_g_q || s1_s_q) && !nv_d;
    flags_d = {nv_d, 3'b000, nx_d};
  end

  logic [INT_W-1:0] s2_data_q;
  logic [4:0]       s2_flags_q;
  logic [TAG_W-1:0] s2_tag_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_int_q   <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_rm_q    <= '0;
      s1_tag_q   <= '0;
      s2_data_q  <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_sign_q <= in_sign;
        s1_nan_q  <= is_nan_d;
        s1_inf_q  <= is_inf_d;
        s1_ovf_q  <= ovf_d;
        s1_int_q  <= int_d;
        s1_g_q    <= g_d;
        s1_s_q    <= s_d;
        s1_uns_q  <= in_unsigned;
        s1_rm_q   <= rm_d;
        s1_tag_q  <= in_tag;
      end
      // Output registers only change on advance, so they hold while stalled.
      if (s1_adv && !flush) begin
        s2_data_q  <= res_d;
        s2_flags_q <= flags_d;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_fflags = s2_flags_q;
  assign out_tag    = s2_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_cvt_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_to_int_cvt_pipe
// Purpose  : Self-checking bench for fp_to_int_cvt_pipe (binary32 -> int32).
//            Expected results come from an exact-arithmetic model of the
//            conversion rules; a scoreboard queue tracks accepted operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_to_int_cvt_pipe;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, in_unsigned;
  logic [31:0] in_data;
  logic [2:0]  in_rm;
  logic [5:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_fflags;
  logic [5:0]  out_tag;

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int emitted = 0;
  logic [5:0] next_tag = 6'd0;

  always #5 clk = ~clk;

  fp_to_int_cvt_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(32), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rm(in_rm), .in_unsigned(in_unsigned), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fflags(out_fflags), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Exact model: value = m * 2^(e-23); round by comparing the discarded
  // remainder against one half, then apply the range rules.
  function automatic void model(input logic [31:0] f, input logic [2:0] rm_in, input logic uns,
                                output logic [31:0] d, output logic [4:0] fl);
    logic neg, nv, inexact, up;
    logic [2:0] rm;
    int ex, sh;
    longint m, e, ip, rem, half, mag, v;
    neg = f[31];
    rm = (rm_in > 3'd4) ? 3'd1 : rm_in;
    ex = int'(f[30:23]);
    m = longint'(f[22:0]);
    nv = 1'b0; inexact = 1'b0; up = 1'b0; d = 32'd0;
    if (ex == 255) begin
      nv = 1'b1;
      if (m != 0 || !neg) d = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
      else                d = uns ? 32'h00000000 : 32'h80000000;
    end else begin
      if (ex == 0) e = -126;
      else begin e = longint'(ex) - 127; m = m + (64'sd1 << 23); end
      if (e >= 23) begin
        ip = (e > 40) ? (64'sd1 << 41) : (m << (e - 23));
        rem = 0; half = 1;
      end else begin
        sh = 23 - int'(e);
        if (sh > 62) begin
          ip = 0; rem = m; half = 64'sh4000_0000_0000_0000;
        end else begin
          ip = m >> sh; rem = m - (ip << sh); half = 64'sd1 << (sh - 1);
        end
      end
      inexact = (rem != 0);
      case (rm)
        3'd0: up = (rem > half) || (rem == half && inexact && ip[0]);
        3'd2: up = neg && inexact;
        3'd3: up = !neg && inexact;
        3'd4: up = inexact && (rem >= half);
        default: up = 1'b0;
      endcase
      mag = ip + (up ? 64'sd1 : 64'sd0);
      v = neg ? -mag : mag;
      if (!uns) begin
        if (v > 64'sd2147483647)       begin d = 32'h7FFFFFFF; nv = 1'b1; end
        else if (v < -64'sd2147483648) begin d = 32'h80000000; nv = 1'b1; end
        else d = v[31:0];
      end else begin
        if (!neg && mag > 64'sd4294967295) begin d = 32'hFFFFFFFF; nv = 1'b1; end
        else if (neg && mag != 0)          begin d = 32'h0; nv = 1'b1; end
        else if (neg)                      d = 32'h0;
        else                               d = mag[31:0];
      end
    end
    fl = {nv, 3'b000, inexact && !nv};
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard / compare process
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  fl;
    logic [5:0]  tag;
  } exp_t;
  exp_t q[$];
  logic        hold_pending = 1'b0;
  logic [63:0] hold_val;

  always @(negedge clk) begin
    exp_t        ed;
    logic [31:0] md;
    logic [4:0]  mf;
    if (rst || flush) begin
      q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", 64'({out_data, out_fflags, out_tag}), hold_val);
      end
      hold_pending = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          emitted++;
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: got tag %0d data 0x%0h, required no output", out_tag, out_data);
          end else begin
            ed = q.pop_front();
            chk("out_data",   64'(out_data),   64'(ed.d));
            chk("out_fflags", 64'(out_fflags), 64'(ed.fl));
            chk("out_tag",    64'(out_tag),    64'(ed.tag));
          end
        end else begin
          hold_pending = 1'b1;
          hold_val = 64'({out_data, out_fflags, out_tag});
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, in_rm, in_unsigned, md, mf);
        q.push_back('{d: md, fl: mf, tag: in_tag});
        accepted++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send(input logic [31:0] f, input logic [2:0] rm, input logic uns);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = f; in_rm = rm; in_unsigned = uns; in_tag = next_tag;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    next_tag = next_tag + 6'd1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    while (q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    int sel;
    logic [31:0] r;
    sel = $urandom_range(0, 19);
    r = $urandom;
    if (sel < 4) return r;
    if (sel == 4) begin
      case ($urandom_range(0, 5))
        0: return 32'h7FC00000;
        1: return 32'h7F800000;
        2: return 32'hFF800000;
        3: return 32'h80000000;
        4: return 32'h00000000;
        default: return 32'hFFC00001;
      endcase
    end
    if (sel == 5) return {r[31], 8'h00, r[22:0]};
    if (sel == 6) return {r[31], 8'd157 + 8'($urandom_range(0, 2)), r[22:0]};
    if (sel == 7) return {r[31], 8'd126 + 8'($urandom_range(0, 1)), r[22:0]};
    return {r[31], 8'($urandom_range(100, 165)), r[22:0]};
  endfunction

  typedef struct {
    logic [31:0] f;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] d;
    logic [4:0]  fl;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] f, input logic [2:0] rm, input logic uns,
                         input logic [31:0] d, input logic [4:0] fl);
    vecs.push_back('{f: f, rm: rm, uns: uns, d: d, fl: fl});
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] md;
    logic [4:0]  mf;
    int acc0, emit0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = '0;
    in_unsigned = 1'b0; in_tag = '0; out_ready = 1'b1;

    // Hand-computed expectations that pin the model.
    add_vec(32'h40490FDB, 3'd1, 1'b0, 32'h00000003, 5'h01);
    add_vec(32'h40200000, 3'd0, 1'b0, 32'h00000002, 5'h01);
    add_vec(32'h40200000, 3'd3, 1'b0, 32'h00000003, 5'h01);
    add_vec(32'h40200000, 3'd4, 1'b0, 32'h00000003, 5'h01);
    add_vec(32'h40200000, 3'd2, 1'b0, 32'h00000002, 5'h01);
    add_vec(32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 5'h01);
    add_vec(32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 5'h10);
    add_vec(32'hCF000000, 3'd0, 1'b0, 32'h80000000, 5'h00);
    add_vec(32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 5'h00);
    add_vec(32'h4F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 5'h10);
    add_vec(32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 5'h10);
    add_vec(32'h7FC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 5'h10);
    add_vec(32'hFF800000, 3'd0, 1'b0, 32'h80000000, 5'h10);
    add_vec(32'h80000000, 3'd0, 1'b0, 32'h00000000, 5'h00);
    add_vec(32'hBF000000, 3'd1, 1'b1, 32'h00000000, 5'h01);
    add_vec(32'hBF000000, 3'd2, 1'b1, 32'h00000000, 5'h10);
    add_vec(32'hBF800000, 3'd0, 1'b1, 32'h00000000, 5'h10);
    add_vec(32'h00000001, 3'd3, 1'b0, 32'h00000001, 5'h01);
    add_vec(32'h80000001, 3'd2, 1'b0, 32'hFFFFFFFF, 5'h01);
    add_vec(32'h3FC00000, 3'd6, 1'b0, 32'h00000001, 5'h01);
    foreach (vecs[i]) begin
      model(vecs[i].f, vecs[i].rm, vecs[i].uns, md, mf);
      chk($sformatf("model_data_%0d", i),  64'(md), 64'(vecs[i].d));
      chk($sformatf("model_flags_%0d", i), 64'(mf), 64'(vecs[i].fl));
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_out_fflags", 64'(out_fflags), 64'd0);
    chk("rst_out_tag",    64'(out_tag),    64'd0);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    @(posedge clk); #1;

    // Directed vectors through the DUT, back to back.
    foreach (vecs[i]) send(vecs[i].f, vecs[i].rm, vecs[i].uns);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 ops are offered.
    acc0 = accepted; emit0 = emitted;
    out_ready = 1'b0;
    send(32'h40490FDB, 3'd0, 1'b0);
    send(32'hC0200000, 3'd2, 1'b0);
    in_valid = 1'b1; in_data = 32'h4F7FFFFF; in_rm = 3'd1; in_unsigned = 1'b1; in_tag = next_tag;
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_accepted_2",   64'(accepted - acc0), 64'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_resume", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; next_tag = next_tag + 6'd1;
    send(32'hBF000000, 3'd1, 1'b1);
    drain();
    chk("bp_accepted_4", 64'(accepted - acc0), 64'd4);
    chk("bp_emitted_4",  64'(emitted - emit0), 64'd4);

    // Flush with two ops in flight and one offered.
    emit0 = emitted;
    out_ready = 1'b0;
    send(32'h40200000, 3'd0, 1'b0);
    send(32'h40200000, 3'd3, 1'b0);
    in_valid = 1'b1; in_data = 32'h40490FDB; in_rm = 3'd0; in_unsigned = 1'b0; in_tag = next_tag;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; next_tag = next_tag + 6'd1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_quiet", 64'(out_valid), 64'd0);
    end
    chk("flush_emitted_none", 64'(emitted - emit0), 64'd0);
    @(posedge clk); #1;

    // Reset mid-stream, then a fresh op must complete in 2 cycles.
    out_ready = 1'b0;
    send(32'h4F000000, 3'd0, 1'b0);
    send(32'hCF000000, 3'd0, 1'b0);
    in_valid = 1'b1; in_data = 32'h3F800000; in_tag = next_tag;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; next_tag = next_tag + 6'd1;
    @(negedge clk);
    chk("rst2_out_valid",  64'(out_valid),  64'd0);
    chk("rst2_out_data",   64'(out_data),   64'd0);
    chk("rst2_out_fflags", 64'(out_fflags), 64'd0);
    chk("rst2_out_tag",    64'(out_tag),    64'd0);
    chk("rst2_in_ready",   64'(in_ready),   64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h40490FDB; in_rm = 3'd1; in_unsigned = 1'b0; in_tag = next_tag;
    @(negedge clk);
    chk("lat_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; next_tag = next_tag + 6'd1;
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    // Randomized traffic with random backpressure and occasional flush.
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = rand_fp();
      in_rm       = 3'($urandom_range(0, 7));
      in_unsigned = 1'($urandom_range(0, 1));
      in_tag      = 6'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
